// File: rtl/scrypt_pkg.sv
// Shared types and sizes for the scrypt scratchpad path.
package scrypt_pkg;

    localparam int unsigned SCRATCH_DATA_W   = 1024;
    localparam int unsigned SCRATCH_ADDR_W   = 17;
    localparam int unsigned SCRATCH_READ_LAT = 2;

    // One in-flight read: valid marks a real read, id names the requester.
    typedef struct packed {
        logic valid;
        logic id;
    } scratch_tag_t;

    // Which requester wins the next tie.
    typedef enum logic {
        RR_FAV0 = 1'b0,
        RR_FAV1 = 1'b1
    } rr_ptr_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
module rr_arbiter2
    import scrypt_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_ptr_t ptr;
    rr_ptr_t ptr_next;

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ptr <= RR_FAV0;
        end else begin
            ptr <= ptr_next;
        end
    end

    // Grant selection; the winner hands priority to the other side.
    always_comb begin
        gnt      = 2'b00;
        ptr_next = ptr;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == RR_FAV0) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            ptr_next = RR_FAV1;
        end else if (gnt[1]) begin
            ptr_next = RR_FAV0;
        end
    end

endmodule

// File: rtl/scratch_arbiter.sv
// Shares one scratchpad SRAM between two scrypt cores, each owning half the space.
module scratch_arbiter
    import scrypt_pkg::*;
#(
    parameter int unsigned ADDR_W   = SCRATCH_ADDR_W,
    parameter int unsigned DATA_W   = SCRATCH_DATA_W,
    parameter int unsigned READ_LAT = SCRATCH_READ_LAT
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-2:0] addr0,
    input  logic [ADDR_W-2:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              scratch_read,
    output logic              scratch_write,
    output logic [ADDR_W-1:0] scratch_addr,
    output logic [DATA_W-1:0] scratch_in,
    input  logic [DATA_W-1:0] scratch_out
);

    localparam int unsigned LADDR_W = ADDR_W - 1;

    logic [1:0]         gnt;
    logic               any_gnt;
    logic               sel_id;
    logic               sel_we;
    logic [LADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    scratch_tag_t       issue_tag;
    scratch_tag_t       tag_out;
    scratch_tag_t       tag_pipe [READ_LAT];

    rr_arbiter2 u_rr (
        .clk   (clk),
        .n_rst (n_rst),
        .req   ({req1, req0}),
        .gnt   (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Select the granted requester's command.
    always_comb begin
        any_gnt   = |gnt;
        sel_id    = gnt[1];
        sel_we    = sel_id ? we1 : we0;
        sel_addr  = sel_id ? addr1 : addr0;
        sel_wdata = sel_id ? wdata1 : wdata0;
    end

    // Tag entering the pipeline is the read currently on the SRAM pins.
    always_comb begin
        issue_tag.valid = scratch_read;
        issue_tag.id    = scratch_addr[ADDR_W-1];
        tag_out         = tag_pipe[READ_LAT-1];
    end

    // Register the granted access onto the SRAM pins.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            scratch_read  <= 1'b0;
            scratch_write <= 1'b0;
            scratch_addr  <= '0;
            scratch_in    <= '0;
        end else begin
            scratch_read  <= any_gnt & ~sel_we;
            scratch_write <= any_gnt & sel_we;
            if (any_gnt) begin
                scratch_addr <= {sel_id, sel_addr};
            end
            if (any_gnt && sel_we) begin
                scratch_in <= sel_wdata;
            end
        end
    end

    // Delay read tags to line up with the SRAM's output data.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int k = 0; k < READ_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int k = 1; k < READ_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    // Capture returning data and steer the valid pulse to its owner.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid0 <= tag_out.valid & ~tag_out.id;
            rvalid1 <= tag_out.valid & tag_out.id;
            if (tag_out.valid) begin
                rdata <= scratch_out;
            end
        end
    end

endmodule

// File: doc/scratch_arbiter.md
Name: scratch_arbiter

Overview:
- Shares the single 1024-bit scrypt scratchpad SRAM between two scrypt cores (requester 0 and requester 1).
- Sits between the cores' scratch ports and the top-level scratch_read/scratch_write/scratch_addr/scratch_in/scratch_out pins.
- Round-robin arbitration, at most one SRAM access per cycle.
- Each requester gets a private half of the address space; read data is routed back to the requester that issued the read, after a fixed SRAM latency.

Parameters:
- ADDR_W, 17: SRAM word-address width. The requester-local address is ADDR_W-1 bits wide.
- DATA_W, 1024: scratch word width.
- READ_LAT, 2: cycles from scratch_read asserted to scratch_out valid (≥1).

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- req0, req1  in  1  access request, held until granted
- we0, we1  in  1  1 = write, 0 = read; valid with req
- addr0, addr1  in  ADDR_W-1  requester-local word address
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  request accepted this cycle (combinational from req and arbiter state)
- rvalid0, rvalid1  out  1  read data valid, 1-cycle pulse
- rdata  out  DATA_W  registered copy of scratch_out; shared by both requesters, qualified by rvalid
- scratch_read  out  1  SRAM read strobe
- scratch_write  out  1  SRAM write strobe
- scratch_addr  out  ADDR_W  SRAM address
- scratch_in  out  DATA_W  SRAM write data
- scratch_out  in  DATA_W  SRAM read data

Behaviour:
- Reset: synchronous on clk rising edge with n_rst=0. All registered outputs clear: scratch_read=0, scratch_write=0, scratch_addr=0, scratch_in=0, rvalid0/1=0, rdata=0. Priority pointer set to requester 0. Tag pipeline cleared.
- Arbitration, combinational each cycle:
  - Only one requester active: it is granted.
  - Both active: grant goes to the requester the pointer favours.
  - On any grant, the pointer flips to favour the other requester next cycle.
  - With no request, the pointer holds.
  - Exactly one gnt is high per cycle at most. Back-to-back grants to the same requester are allowed when the other is idle.
- Issue, registered, 1 cycle after grant:
  - scratch_addr = {requester id, local addr}, i.e. MSB = 0 for req0 and 1 for req1.
  - scratch_write = we and scratch_read = ~we for the granted request; both 0 when nothing is granted.
  - scratch_in = wdata of the granted requester on writes; holds its previous value otherwise.
- Read return:
  - A 2-bit tag {valid, id} shift register of depth READ_LAT tracks each issued read.
  - When the tag exits the pipeline, scratch_out is registered into rdata and the rvalid of the matching id pulses for 1 cycle.
  - Total read latency from gnt to rvalid = READ_LAT+2 cycles. Writes never produce rvalid.
- Throughput: one access per cycle sustained; reads and writes may interleave freely. There is no ordering hazard beyond SRAM semantics: a read issued the cycle after a write to the same address returns the new data (SRAM write-first).
- Requester rules: req must stay high, with we/addr/wdata stable, until gnt. Deasserting req before gnt is legal and simply drops the request.
- Reset mid-operation: in-flight read tags are discarded, no rvalid is produced afterwards, and the SRAM strobes are low the cycle after reset. Requesters must reissue.
- Simultaneous events: a new grant and an rvalid in the same cycle are independent. rvalid0 and rvalid1 are never high together.

Decomposition:
- Shared package scrypt_pkg:
  - localparam SCRATCH_DATA_W = 1024
  - localparam SCRATCH_ADDR_W = 17
  - typedef scratch_tag_t (struct: valid, id)
- One sub-module: rr_arbiter2. It holds the two-input round-robin grant logic and the pointer register, with clk/n_rst, req[1:0], gnt[1:0].
- The tag pipeline and datapath muxing stay in scratch_arbiter.

Test Plan:
- Reset then idle: all outputs 0 for 10 cycles; pulse req0 read addr 0x0005 → gnt0 same cycle, scratch_read=1 and scratch_addr=0x00005 next cycle, rvalid0 with rdata = SRAM model word exactly READ_LAT+2 cycles after gnt.
- Contention: req0 and req1 both held 6 cycles → grants alternate 0,1,0,1,0,1; scratch_addr MSB alternates accordingly.
- Partitioning: req1 writes 0xA5..A5 to local 0x0003, then reads it back → scratch_addr=0x10003 for both; rvalid1 returns 0xA5..A5. A req0 read of local 0x0003 returns the req0-half contents, not 0xA5..A5.
- Streaming: req0 issues 8 back-to-back reads with req1 idle → 8 consecutive rvalid0 pulses in issue order, no rvalid1.
- Write-only: req1 issues 4 writes → 4 scratch_write pulses, zero rvalid pulses.
- Reset mid-read: gnt0 read, then n_rst=0 for 1 cycle one cycle later → no rvalid0 ever appears, scratch_read=0 after reset, pointer favours req0.
